led_code_decoder: RTL and testbench

LED_CODE_DECODER -- requirements
Module: led_code_decoder

---
 rtl/led_code_decoder.sv | 150 +++++++++++++++
 tb/tb_led_code_decoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_code_decoder.sv
`default_nettype none
// ============================================================================
// Module   : led_code_decoder
// Brief    : Debounces an 8-bit LED bar pattern and decodes it to 0..15.
// Revision : 1.0
// ============================================================================
module led_code_decoder #(
    parameter int STABLE_N = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       din,
    input  logic             din_valid,
    input  logic             dout_ready,
    output logic [3:0]       dout,
    output logic             dout_valid,
    output logic             code_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             busy
);

    localparam logic [3:0] C_STABLE = 4'(STABLE_N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL    = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cand_q, cand_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       dout_q, dout_d;
    logic             code_err_q, code_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [4:0]       w_dec;
    logic             w_capture;

    // Returns {illegal, value}; illegal patterns report value 0.
    function automatic logic [4:0] decode(input logic [7:0] p);
        case (p)
            8'h00: decode = 5'd0;
            8'h01: decode = 5'd1;
            8'h02: decode = 5'd2;
            8'h04: decode = 5'd3;
            8'h08: decode = 5'd4;
            8'h10: decode = 5'd5;
            8'h20: decode = 5'd6;
            8'h40: decode = 5'd7;
            8'h80: decode = 5'd8;
            8'h03: decode = 5'd9;
            8'h07: decode = 5'd10;
            8'h0F: decode = 5'd11;
            8'h1F: decode = 5'd12;
            8'h3F: decode = 5'd13;
            8'h7F: decode = 5'd14;
            8'hFF: decode = 5'd15;
            default: decode = 5'b1_0000;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        code_err_d = code_err_q;
        err_cnt_d  = err_cnt_q;
        w_dec      = decode(din);
        w_capture  = 1'b0;

        case (state_q)
            IDLE: begin
                if (din_valid) w_capture = 1'b1;
            end
            QUAL: begin
                if (!din_valid) begin
                    state_d = IDLE;
                    cand_d  = 8'h00;
                    cnt_d   = 4'd0;
                end else if (din == cand_q) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == C_STABLE) begin
                        state_d                = HOLD;
                        {code_err_d, dout_d}   = w_dec;
                    end
                end else begin
                    w_capture = 1'b1;
                end
            end
            HOLD: begin
                if (dout_ready) begin
                    state_d = RELEASE;
                    cnt_d   = 4'd0;
                    if (code_err_q && (err_cnt_q != '1))
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                end
            end
            RELEASE: begin
                // cand_q still holds the transferred pattern, suppressing re-emission.
                if (!din_valid) begin
                    state_d = IDLE;
                    cand_d  = 8'h00;
                end else if (din != cand_q) begin
                    w_capture = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_capture) begin
            cand_d = din;
            cnt_d  = 4'd1;
            if (STABLE_N == 1) begin
                state_d              = HOLD;
                {code_err_d, dout_d} = w_dec;
            end else begin
                state_d = QUAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cand_q     <= 8'h00;
            cnt_q      <= 4'd0;
            dout_q     <= 4'd0;
            code_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            code_err_q <= code_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign dout       = dout_q;
    assign code_err   = code_err_q;
    assign err_cnt    = err_cnt_q;
    assign dout_valid = (state_q == HOLD);
    assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_led_code_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_code_decoder
// Brief    : Randomized scoreboard bench for led_code_decoder.
// Revision : 1.0
// ============================================================================
module tb_led_code_decoder;

    localparam int STABLE_N = 3;
    localparam int ERR_W    = 2;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       din = 8'h00;
    logic             din_valid = 1'b0;
    logic             dout_ready = 1'b0;
    logic [3:0]       dout;
    logic             dout_valid;
    logic             code_err;
    logic [ERR_W-1:0] err_cnt;
    logic             busy;

    led_code_decoder #(.STABLE_N(STABLE_N), .ERR_W(ERR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .code_err   (code_err),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       d;
        logic             e;
        logic [ERR_W-1:0] ec;
        int               vc;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Legal codes: 0, one-hot (bit k -> k+1), thermometer of 2..8 ones (-> ones+7).
    function automatic logic [4:0] ref_decode(input logic [7:0] p);
        int ones;
        int q;
        ones = $countones(p);
        q    = int'(p);
        if (q == 0) return 5'd0;
        if (ones == 1) return {1'b0, 4'($clog2(q) + 1)};
        if (((q + 1) & q) == 0) return {1'b0, 4'(ones + 7)};
        return 5'b1_0000;
    endfunction

    bit         m_pend;
    bit         m_sup;
    logic [7:0] m_run_pat, m_held, m_sup_pat;
    int         m_run_len;
    int         m_err;

    task automatic model_reset();
        sb.delete();
        m_pend = 0; m_sup = 0; m_run_len = 0; m_err = 0;
        m_run_pat = 8'h00; m_held = 8'h00; m_sup_pat = 8'h00;
    endtask

    // Predicts the effect of the upcoming clock edge given the applied inputs.
    task automatic model_step(input bit v, input logic [7:0] d, input bit r);
        logic [4:0] dec;
        if (m_pend) begin
            if (r) begin
                m_pend = 0; m_sup = 1; m_sup_pat = m_held;
            end
        end else if (!v) begin
            m_run_len = 0; m_sup = 0;
        end else if (!(m_sup && d == m_sup_pat)) begin
            m_sup = 0;
            if (m_run_len > 0 && d == m_run_pat) m_run_len++;
            else begin
                m_run_pat = d; m_run_len = 1;
            end
            if (m_run_len == STABLE_N) begin
                m_pend = 1; m_held = d; m_run_len = 0;
                dec = ref_decode(d);
                if (dec[4] && m_err < ERR_MAX) m_err++;
                sb.push_back('{dec[3:0], dec[4], ERR_W'(m_err), cyc + 1});
            end
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit r);
        din = d; din_valid = v; dout_ready = r;
        model_step(v, d, r);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reset pulsed between clock edges; outputs must clear without waiting for clk.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst dout_valid", int'(dout_valid), 0);
        check("rst busy", int'(busy), 0);
        check("rst dout", int'(dout), 0);
        check("rst code_err", int'(code_err), 0);
        check("rst err_cnt", int'(err_cnt), 0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    bit             mon_seen = 0;
    bit             mon_echk = 0;
    logic [ERR_W-1:0] mon_eexp;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_seen = 0;
            mon_echk = 0;
        end else begin
            if (mon_echk) begin
                checks++;
                if (err_cnt !== mon_eexp) begin
                    errors++;
                    $display("FAIL err_cnt after transfer: got %0d expected %0d", err_cnt, mon_eexp);
                end
                mon_echk = 0;
            end
            if (dout_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected dout_valid at cycle %0d: dout=%0d code_err=%0b", cyc, dout, code_err);
                end else begin
                    if (!mon_seen) begin
                        mon_seen = 1;
                        if (cyc != sb[0].vc) begin
                            errors++;
                            $display("FAIL latency: valid at cycle %0d expected %0d", cyc, sb[0].vc);
                        end
                    end
                    checks++;
                    if (dout !== sb[0].d || code_err !== sb[0].e) begin
                        errors++;
                        $display("FAIL result: got dout=%0d err=%0b expected dout=%0d err=%0b",
                                 dout, code_err, sb[0].d, sb[0].e);
                    end
                    if (dout_ready) begin
                        mon_eexp = sb[0].ec;
                        mon_echk = 1;
                        void'(sb.pop_front());
                        mon_seen = 0;
                    end
                end
            end
        end
    end

    logic [7:0] pats [8] = '{8'h00, 8'h01, 8'h04, 8'h03, 8'hFF, 8'h09, 8'h05, 8'h7F};

    initial begin
        logic [7:0] rd;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset dout_valid", int'(dout_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset dout", int'(dout), 0);
        check("reset code_err", int'(code_err), 0);
        check("reset err_cnt", int'(err_cnt), 0);
        rst_n = 1'b1;

        // Reset while a result is held: dropped, and a fresh qualification works after.
        repeat (3) step(1, 8'h3F, 0);
        step(0, 8'h00, 0);
        do_reset();
        repeat (3) step(1, 8'h01, 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);

        repeat (3) step(1, 8'h1F, 1);
        repeat (2) step(0, 8'h00, 1);

        step(1, 8'h07, 1); step(1, 8'h07, 1);
        repeat (3) step(1, 8'h0F, 1);
        repeat (2) step(0, 8'h00, 1);

        // Illegal code held while downstream stalls.
        repeat (3) step(1, 8'h05, 0);
        repeat (4) step(0, 8'h00, 0);
        step(0, 8'h00, 1);
        repeat (2) step(0, 8'h00, 1);
        check("idle busy", int'(busy), 0);

        do_reset();
        for (int k = 0; k < 4; k++) begin
            repeat (3) step(1, 8'h09, 1);
            step(0, 8'h00, 1);
            step(0, 8'h00, 1);
        end
        check("err_cnt saturated", int'(err_cnt), 3);

        repeat (20) step(1, 8'hFF, 1);
        step(0, 8'h00, 1);
        repeat (3) step(1, 8'hFF, 1);
        repeat (2) step(0, 8'h00, 1);

        rd = pats[0];
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2) == 0) rd = pats[$urandom_range(7)];
            step(($urandom_range(7) != 0), rd, ($urandom_range(2) != 0));
        end

        repeat (10) step(0, 8'h00, 1);
        check("scoreboard drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
